// File: rtl/nibble_add_pkg.sv
// rtl/nibble_add_pkg.sv - shared types and sizing helpers for the nibble-serial adder
package nibble_add_pkg;

    localparam int NIB_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        ADD  = 1'b1
    } state_t;

    // One spare bit so the count to NIBBLES-1 never wraps, even for NIBBLES=1.
    function automatic int cnt_width(input int nibbles);
        return $clog2(nibbles) + 1;
    endfunction

endpackage

// File: rtl/nibble_add_seq_add4_slice.sv
// rtl/nibble_add_seq_add4_slice.sv - combinational 4-bit ripple-carry adder slice
module add4_slice (
    output logic [3:0] Sum,
    output logic       co,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       cin
);

    logic [4:0] w_c;

    assign w_c[0] = cin;

    for (genvar i = 0; i < 4; i++) begin : g_bit
        assign Sum[i]   = A[i] ^ B[i] ^ w_c[i];
        assign w_c[i+1] = (A[i] & B[i]) | (w_c[i] & (A[i] ^ B[i]));
    end

    assign co = w_c[4];

endmodule

// File: rtl/nibble_add_seq.sv
// rtl/nibble_add_seq.sv - nibble-serial wide adder; NIBBLE_ADD_SEQ_SUB_EN adds a subtract mode
module nibble_add_seq
    import nibble_add_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [NIB_W*NIBBLES-1:0] a,
    input  logic [NIB_W*NIBBLES-1:0] b,
    input  logic                     cin,
`ifdef NIBBLE_ADD_SEQ_SUB_EN
    input  logic                     sub,
`endif
    output logic                     busy,
    output logic                     done,
    output logic [NIB_W*NIBBLES-1:0] sum,
    output logic                     cout
);

    localparam int W     = NIB_W * NIBBLES;
    localparam int CNT_W = cnt_width(NIBBLES);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [W-1:0]     r_a_sh;
    logic [W-1:0]     r_b_sh;
    logic [W-1:0]     r_acc_sh;
    logic [W-1:0]     r_sum;
    logic             r_carry;
    logic             r_cout;
    logic             r_done;
    logic [CNT_W-1:0] r_cnt;

    logic [W-1:0]     w_acc_nxt;
    logic [W-1:0]     w_b_in;
    logic             w_cin_in;
    logic [3:0]       w_slice_sum;
    logic             w_slice_co;
    logic             w_accept;
    logic             w_last;

`ifdef NIBBLE_ADD_SEQ_SUB_EN
    // a - b - cin == a + ~b + ~cin; a final carry of 1 means no borrow.
    assign w_b_in   = sub ? ~b : b;
    assign w_cin_in = sub ? ~cin : cin;
`else
    assign w_b_in   = b;
    assign w_cin_in = cin;
`endif

    add4_slice u_slice (
        .Sum (w_slice_sum),
        .co  (w_slice_co),
        .A   (r_a_sh[NIB_W-1:0]),
        .B   (r_b_sh[NIB_W-1:0]),
        .cin (r_carry)
    );

    if (NIBBLES == 1) begin : g_acc_one
        assign w_acc_nxt = w_slice_sum;
    end else begin : g_acc_many
        assign w_acc_nxt = {w_slice_sum, r_acc_sh[W-1:NIB_W]};
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ADD;
                end
            end
            ADD: begin
                w_last = (r_cnt == CNT_W'(NIBBLES - 1));
                if (w_last) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_acc_sh <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_a_sh  <= a;
                r_b_sh  <= w_b_in;
                r_carry <= w_cin_in;
                r_cnt   <= '0;
            end else if (r_state == ADD) begin
                r_a_sh   <= r_a_sh >> NIB_W;
                r_b_sh   <= r_b_sh >> NIB_W;
                r_acc_sh <= w_acc_nxt;
                r_carry  <= w_slice_co;
                r_cnt    <= r_cnt + CNT_W'(1);
                if (w_last) begin
                    r_sum  <= w_acc_nxt;
                    r_cout <= w_slice_co;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign busy = (r_state == ADD);
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_nibble_add_seq.sv
// tb/tb_nibble_add_seq.sv - randomized model-checked bench for nibble_add_seq (NIBBLES=4 and 1)
module tb_nibble_add_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start4, cin4, sub4;
    logic [15:0] a4, b4;
    logic        busy4, done4, cout4;
    logic [15:0] sum4;
    logic        start1, cin1, sub1;
    logic [3:0]  a1, b1;
    logic        busy1, done1, cout1;
    logic [3:0]  sum1;

    int          n_checks = 0;
    int          n_fail   = 0;
    bit          chk_en   = 0;
    int          cyc      = 0;

    int          m_left [2];
    logic [31:0] m_pend [2];
    logic [31:0] m_res  [2];
    logic        m_done [2];

    always #5 clk = ~clk;

    nibble_add_seq #(.NIBBLES(4)) u_dut4 (
        .clk   (clk),
        .rst   (rst),
        .start (start4),
        .a     (a4),
        .b     (b4),
        .cin   (cin4),
`ifdef NIBBLE_ADD_SEQ_SUB_EN
        .sub   (sub4),
`endif
        .busy  (busy4),
        .done  (done4),
        .sum   (sum4),
        .cout  (cout4)
    );

    nibble_add_seq #(.NIBBLES(1)) u_dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .cin   (cin1),
`ifdef NIBBLE_ADD_SEQ_SUB_EN
        .sub   (sub1),
`endif
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", nm, act, exp, cyc);
        end
    endtask

    // Full-width result: bit w is the carry-out, bits w-1:0 the sum.
    function automatic logic [31:0] calc(input int w, input logic [15:0] a, input logic [15:0] b,
                                         input logic c, input logic s);
        logic [31:0] mask;
        mask = (32'd1 << w) - 32'd1;
        if (s)
            return {16'b0, a} + ((~{16'b0, b}) & mask) + 32'(~c);
        return {16'b0, a} + {16'b0, b} + 32'(c);
    endfunction

    task automatic step(input int k, input int w, input logic st, input logic [15:0] a,
                        input logic [15:0] b, input logic c, input logic s, input int nib);
        if (rst) begin
            m_left[k] = 0;
            m_done[k] = 1'b0;
            m_res[k]  = '0;
        end else if (m_left[k] == 0) begin
            m_done[k] = 1'b0;
            if (st) begin
                m_left[k] = nib;
                m_pend[k] = calc(w, a, b, c, s);
            end
        end else begin
            m_left[k]--;
            m_done[k] = (m_left[k] == 0);
            if (m_left[k] == 0) m_res[k] = m_pend[k];
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        step(0, 16, start4, a4, b4, cin4, sub4, 4);
        step(1, 4, start1, {12'b0, a1}, {12'b0, b1}, cin1, sub1, 1);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy4", busy4, m_left[0] != 0);
            chk("done4", done4, m_done[0]);
            chk("sum4",  sum4,  m_res[0][15:0]);
            chk("cout4", cout4, m_res[0][16]);
            chk("busy1", busy1, m_left[1] != 0);
            chk("done1", done1, m_done[1]);
            chk("sum1",  sum1,  m_res[1][3:0]);
            chk("cout1", cout1, m_res[1][4]);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic go4(input logic [15:0] a, input logic [15:0] b, input logic c);
        a4 = a; b4 = b; cin4 = c; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        a4 = 16'($urandom); b4 = 16'($urandom); cin4 = 1'($urandom);
    endtask

    task automatic wait_done4(output int busy_cnt);
        bit ok;
        busy_cnt = 0;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (done4) begin
                ok = 1;
                break;
            end
            if (busy4) busy_cnt++;
            tick();
        end
        if (!ok) chk("done4_timeout", done4, 1);
    endtask

    initial begin
        int bc, nd;
        int dcyc [$];

        rst = 1'b1;
        start4 = 0; a4 = 0; b4 = 0; cin4 = 0; sub4 = 0;
        start1 = 0; a1 = 0; b1 = 0; cin1 = 0; sub1 = 0;
        repeat (2) tick();
        rst = 1'b0;
        chk_en = 1;
        chk("rst_busy", busy4, 0);
        chk("rst_done", done4, 0);
        chk("rst_sum",  sum4,  0);
        chk("rst_cout", cout4, 0);

        go4(16'hFFFF, 16'h0001, 1'b0);
        wait_done4(bc);
        chk("t1_busy_cycles", bc, 4);
        chk("t1_sum",  sum4,  16'h0000);
        chk("t1_cout", cout4, 1);

        go4(16'h1234, 16'h4321, 1'b1);
        wait_done4(bc);
        chk("t2_sum",  sum4,  16'h5556);
        chk("t2_cout", cout4, 0);
        nd = 0;
        repeat (20) begin
            tick();
            if (done4) nd++;
        end
        chk("t2_hold_sum", sum4, 16'h5556);
        chk("t2_hold_dones", nd, 0);

        go4(16'h1111, 16'h2222, 1'b0);
        tick();
        a4 = 16'hAAAA; b4 = 16'h5555; cin4 = 1'b1; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        nd = 0;
        repeat (12) begin
            if (done4) nd++;
            tick();
        end
        chk("t3_dones", nd, 1);
        chk("t3_sum", sum4, 16'h3333);

        go4(16'hF0F0, 16'h0F0F, 1'b1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t4_busy", busy4, 0);
        chk("t4_done", done4, 0);
        chk("t4_sum",  sum4,  0);
        chk("t4_cout", cout4, 0);
        go4(16'h00FF, 16'h0101, 1'b0);
        wait_done4(bc);
        chk("t4_busy_cycles", bc, 4);
        chk("t4_sum2", sum4, 16'h0200);

        tick();
        a4 = 16'h000F; b4 = 16'h0001; cin4 = 1'b0; start4 = 1'b1;
        for (int i = 0; i < 40 && dcyc.size() < 3; i++) begin
            tick();
            if (done4) begin
                dcyc.push_back(cyc);
                chk("t5_sum", sum4, 16'h0010);
            end
        end
        start4 = 1'b0;
        chk("t5_done_count", dcyc.size(), 3);
        if (dcyc.size() == 3) begin
            chk("t5_gap1", dcyc[1] - dcyc[0], 5);
            chk("t5_gap2", dcyc[2] - dcyc[1], 5);
        end
        repeat (8) tick();

        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int c = 0; c < 2; c++) begin
                    a1 = 4'(a); b1 = 4'(b); cin1 = 1'(c); start1 = 1'b1;
                    tick();
                    start1 = 1'b0;
                    tick();
                    chk("sweep_done", done1, 1);
                    chk("sweep_sum", {27'b0, cout1, sum1}, 32'(a + b + c));
                end

`ifdef NIBBLE_ADD_SEQ_SUB_EN
        a1 = 4'd5; b1 = 4'd7; cin1 = 1'b0; sub1 = 1'b1; start1 = 1'b1;
        tick();
        start1 = 1'b0; sub1 = 1'b0;
        tick();
        chk("sub_sum",  sum1,  4'hE);
        chk("sub_cout", cout1, 0);
`endif

        repeat (2000) begin
            start4 = ($urandom_range(0, 2) == 0);
            a4 = 16'($urandom); b4 = 16'($urandom); cin4 = 1'($urandom);
            start1 = ($urandom_range(0, 2) == 0);
            a1 = 4'($urandom); b1 = 4'($urandom); cin1 = 1'($urandom);
`ifdef NIBBLE_ADD_SEQ_SUB_EN
            sub4 = 1'($urandom); sub1 = 1'($urandom);
`endif
            rst = ($urandom_range(0, 149) == 0);
            tick();
        end
        rst = 1'b0; start4 = 1'b0; start1 = 1'b0;
        repeat (8) tick();

        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
